// File: rtl/tick_fifo_reader.sv
// tick_fifo_reader: pops one FIFO word per rising tick edge and holds it on data_o.
// Runs the FIFO read handshake with a configurable read latency and queues one pending tick.
// Ticks that find the FIFO empty are counted by a saturating underflow counter.
module tick_fifo_reader #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned UFLOW_W    = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic               en_i,
  input  logic               fifo_empty_i,
  output logic               fifo_rd_o,
  input  logic [DATA_W-1:0]  fifo_q_i,
  output logic [DATA_W-1:0]  data_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic [UFLOW_W-1:0] underflow_cnt_o
);

  // Two bits cover the legal read latencies 1..3.
  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LATENCY);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               tick_q;
  logic               pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_d;
  logic               valid_d;
  logic               busy_d;
  logic [DATA_W-1:0]  data_d;
  logic [UFLOW_W-1:0] ucnt_d;
  logic               req;
  logic               service;

  // Rising-edge request, gated by the enable.
  assign req     = tick_i & ~tick_q & en_i;
  // A queued tick is only honoured while the reader is still enabled.
  assign service = req | (pending_q & en_i);

  // Registered state, history and outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      tick_q          <= 1'b0;
      pending_q       <= 1'b0;
      cnt_q           <= '0;
      fifo_rd_o       <= 1'b0;
      valid_o         <= 1'b0;
      busy_o          <= 1'b0;
      data_o          <= '0;
      underflow_cnt_o <= '0;
    end else begin
      state_q         <= state_d;
      tick_q          <= tick_i;
      pending_q       <= pending_d;
      cnt_q           <= cnt_d;
      fifo_rd_o       <= rd_d;
      valid_o         <= valid_d;
      busy_o          <= busy_d;
      data_o          <= data_d;
      underflow_cnt_o <= ucnt_d;
    end
  end

  // Next-state, pending flag, latency counter and next output values.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    rd_d      = 1'b0;
    valid_d   = 1'b0;
    data_d    = data_o;
    ucnt_d    = underflow_cnt_o;

    case (state_q)
      ST_IDLE: begin
        if (service) begin
          pending_d = 1'b0;
          if (!fifo_empty_i) begin
            rd_d    = 1'b1;
            cnt_d   = LAT_LOAD;
            state_d = ST_WAIT;
          end else if (underflow_cnt_o != '1) begin
            ucnt_d = underflow_cnt_o + UFLOW_W'(1);
          end
        end
      end
      ST_WAIT: begin
        // Only one tick can be queued; extra ones re-set an already-set flag.
        if (req) pending_d = 1'b1;
        if (cnt_q == '0) begin
          data_d  = fifo_q_i;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!en_i) pending_d = 1'b0;
  end

  assign busy_d = (state_d == ST_WAIT);

endmodule

// File: tb/tb_tick_fifo_reader.sv
// Testbench for tick_fifo_reader: directed vector table, corner-case sequences and
// randomized traffic checked against a cycle-scheduled reference model.
module tb_tick_fifo_reader;

  localparam int unsigned L  = 1;
  localparam int unsigned NC = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick, en, empty_m, empty_l3, empty_u2;
  logic       rd_m, rd_l3, rd_u2;
  logic       valid_m, valid_l3, valid_u2;
  logic       busy_m, busy_l3, busy_u2;
  logic [7:0] q_m, q_l3, q_u2;
  logic [7:0] data_m, data_l3, data_u2;
  logic [7:0] ucnt_m, ucnt_l3;
  logic [1:0] ucnt_u2;

  tick_fifo_reader #(.DATA_W(8), .RD_LATENCY(1), .UFLOW_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .en_i(en), .fifo_empty_i(empty_m),
    .fifo_rd_o(rd_m), .fifo_q_i(q_m), .data_o(data_m), .valid_o(valid_m),
    .busy_o(busy_m), .underflow_cnt_o(ucnt_m));

  tick_fifo_reader #(.DATA_W(8), .RD_LATENCY(3), .UFLOW_W(8)) dut_l3 (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .en_i(en), .fifo_empty_i(empty_l3),
    .fifo_rd_o(rd_l3), .fifo_q_i(q_l3), .data_o(data_l3), .valid_o(valid_l3),
    .busy_o(busy_l3), .underflow_cnt_o(ucnt_l3));

  tick_fifo_reader #(.DATA_W(8), .RD_LATENCY(1), .UFLOW_W(2)) dut_u2 (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .en_i(en), .fifo_empty_i(empty_u2),
    .fifo_rd_o(rd_u2), .fifo_q_i(q_u2), .data_o(data_u2), .valid_o(valid_u2),
    .busy_o(busy_u2), .underflow_cnt_o(ucnt_u2));

  // FIFO environment models
  logic [7:0] env_q[$];
  logic [7:0] l3_q[$];
  logic [7:0] ref_q[$];
  logic [7:0] p3[3];

  always @(posedge clk) begin
    if (rd_m === 1'b1 && env_q.size() > 0) q_m <= env_q.pop_front();
  end

  always @(posedge clk) begin
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (rd_l3 === 1'b1 && l3_q.size() > 0) p3[0] <= l3_q.pop_front();
  end
  assign q_l3 = p3[2];

  // Scoreboard state
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_seen = 0, valid_seen = 0;
  int l3_valid_cnt = 0, l3_valid_cyc = -1;
  logic [7:0] l3_last_data;

  // Reference model: each accepted read is scheduled as absolute cycle numbers.
  bit         exp_rd[NC];
  bit         exp_valid[NC];
  bit         exp_busy[NC];
  logic [7:0] exp_vdata[NC];
  logic [7:0] m_data;
  int         m_ucnt;
  bit         m_pending, m_prev_tick;
  int         m_idle_from;

  typedef struct {
    bit         tick;
    bit         en;
    bit         rd;
    bit         valid;
    bit         busy;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // One cycle: check this cycle's outputs, drive its inputs, advance the model.
  task automatic step(input bit t, input bit e, input bit r, input bit push, input logic [7:0] w);
    bit req, idle;
    logic [7:0] w0;
    @(negedge clk);
    if (cyc > 0) begin
      if (exp_valid[cyc]) m_data = exp_vdata[cyc];
      chk("rd",    32'(rd_m),    32'(exp_rd[cyc]));
      chk("valid", 32'(valid_m), 32'(exp_valid[cyc]));
      chk("busy",  32'(busy_m),  32'(exp_busy[cyc]));
      chk("data",  32'(data_m),  32'(m_data));
      chk("ucnt",  32'(ucnt_m),  32'(m_ucnt));
    end
    if (rd_m === 1'b1) rd_seen++;
    if (valid_m === 1'b1) valid_seen++;
    if (valid_l3 === 1'b1) begin
      l3_valid_cnt++;
      l3_valid_cyc = cyc;
      l3_last_data = data_l3;
    end
    tick = t;
    en   = e;
    rst  = r;
    if (push) begin
      env_q.push_back(w);
      ref_q.push_back(w);
    end
    empty_m  = (env_q.size() == 0);
    empty_l3 = (l3_q.size() == 0);

    if (r) begin
      m_prev_tick = 1'b0;
      m_pending   = 1'b0;
      m_idle_from = cyc + 1;
      m_ucnt      = 0;
      m_data      = 8'h00;
      for (int c = cyc + 1; c <= cyc + 6; c++) begin
        exp_rd[c] = 1'b0; exp_valid[c] = 1'b0; exp_busy[c] = 1'b0;
      end
    end else begin
      req = t && !m_prev_tick && e;
      m_prev_tick = t;
      idle = (cyc >= m_idle_from);
      if (idle && (req || (m_pending && e))) begin
        m_pending = 1'b0;
        if (!empty_m) begin
          w0 = ref_q.pop_front();
          exp_rd[cyc + 1] = 1'b1;
          for (int c = cyc + 1; c <= cyc + 1 + int'(L); c++) exp_busy[c] = 1'b1;
          exp_valid[cyc + 2 + int'(L)] = 1'b1;
          exp_vdata[cyc + 2 + int'(L)] = w0;
          m_idle_from = cyc + 2 + int'(L);
        end else if (m_ucnt < 255) begin
          m_ucnt++;
        end
      end else if (!idle && req) begin
        m_pending = 1'b1;
      end
      if (!e) m_pending = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic reset_all();
    env_q.delete();
    ref_q.delete();
    l3_q.delete();
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    int r0, v0, k, lv0;
    rst = 1'b1; tick = 1'b0; en = 1'b1;
    empty_m = 1'b1; empty_l3 = 1'b1; empty_u2 = 1'b1;
    q_m = 8'h00; q_u2 = 8'h00;
    p3[0] = 8'h00; p3[1] = 8'h00; p3[2] = 8'h00;
    m_data = 8'h00; m_ucnt = 0; m_pending = 1'b0; m_prev_tick = 1'b0; m_idle_from = 0;
    l3_last_data = 8'h00;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};

    // Reset state
    reset_all();
    reset_all();
    idle_steps(1);
    chk("rst_rd",    32'(rd_m),    32'd0);
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_busy",  32'(busy_m),  32'd0);
    chk("rst_data",  32'(data_m),  32'd0);
    chk("rst_ucnt",  32'(ucnt_m),  32'd0);

    // Empty FIFO: ticks only count underflows; 2-bit counter saturates
    r0 = rd_seen;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end
    idle_steps(1);
    chk("uflow3",    32'(ucnt_m),  32'd3);
    chk("u2_uflow3", 32'(ucnt_u2), 32'd3);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end
    idle_steps(1);
    chk("uflow5",    32'(ucnt_m),  32'd5);
    chk("u2_sat",    32'(ucnt_u2), 32'd3);
    chk("uflow_nord", 32'(rd_seen - r0), 32'd0);
    chk("u2_rd",    32'(rd_u2),    32'd0);
    chk("u2_valid", 32'(valid_u2), 32'd0);
    chk("u2_busy",  32'(busy_u2),  32'd0);
    chk("u2_data",  32'(data_u2),  32'd0);

    // Vector table: single read then back-to-back with a pending tick
    reset_all();
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].tick, tbl[i].en, 1'b0, 1'b0, 8'h00);
      chk($sformatf("tbl%0d_rd", i),    32'(rd_m),    32'(tbl[i].rd));
      chk($sformatf("tbl%0d_valid", i), 32'(valid_m), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_busy", i),  32'(busy_m),  32'(tbl[i].busy));
      chk($sformatf("tbl%0d_data", i),  32'(data_m),  32'(tbl[i].data));
    end

    // Tick held high for five cycles gives exactly one read
    reset_all();
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h22);
    r0 = rd_seen; v0 = valid_seen;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle_steps(6);
    chk("held_rd",    32'(rd_seen - r0),    32'd1);
    chk("held_valid", 32'(valid_seen - v0), 32'd1);
    chk("held_data",  32'(data_m),          32'h11);

    // Disabled ticks are ignored; disabling clears a queued tick
    reset_all();
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h33);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h44);
    r0 = rd_seen;
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle_steps(5);
    chk("dis_rd",   32'(rd_seen - r0), 32'd0);
    chk("dis_ucnt", 32'(ucnt_m),       32'd0);
    r0 = rd_seen; v0 = valid_seen;
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    idle_steps(6);
    chk("pend_clr_rd",    32'(rd_seen - r0),    32'd1);
    chk("pend_clr_valid", 32'(valid_seen - v0), 32'd1);
    chk("pend_clr_data",  32'(data_m),          32'h33);

    // Reset with a read in flight discards the word
    reset_all();
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
    v0 = valid_seen;
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("inflight_busy", 32'(busy_m), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("mrst_rd",    32'(rd_m),    32'd0);
    chk("mrst_valid", 32'(valid_m), 32'd0);
    chk("mrst_busy",  32'(busy_m),  32'd0);
    chk("mrst_data",  32'(data_m),  32'd0);
    chk("mrst_ucnt",  32'(ucnt_m),  32'd0);
    idle_steps(4);
    chk("mrst_novalid", 32'(valid_seen - v0), 32'd0);

    // Three-cycle read latency: tick at k, valid at k+5
    reset_all();
    l3_q.push_back(8'hA1);
    idle_steps(1);
    lv0 = l3_valid_cnt;
    k = cyc;
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle_steps(8);
    chk("l3_count", 32'(l3_valid_cnt - lv0), 32'd1);
    chk("l3_cycle", 32'(l3_valid_cyc),       32'(k + 5));
    chk("l3_data",  32'(l3_last_data),       32'hA1);
    chk("l3_ucnt",  32'(ucnt_l3),            32'd0);
    chk("l3_busy",  32'(busy_l3),            32'd0);

    // Randomized traffic against the reference model
    reset_all();
    for (int i = 0; i < 3000; i++) begin
      bit rr, tt, ee, pp;
      rr = ($urandom_range(149) == 0);
      tt = ($urandom_range(2) == 0);
      ee = ($urandom_range(7) != 0);
      pp = ($urandom_range(2) == 0) && (env_q.size() < 6);
      step(tt, ee, rr, pp, 8'($urandom));
    end
    idle_steps(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
